conv_window_ctrl: RTL and testbench

Sequencer for the convolution line-buffer datapath: it accepts the raster pixel stream, drives the shift enable of the KERNEL-1 row delay lines and the window register array, and flags the cycles in which the sliding KERNEL×KERNEL window is complete and stride-aligned. It sits between the pixel source and the line-buffer/MAC stage of each conv layer, handles output backpressure, and signals end of frame.

---
 rtl/conv_window_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl.sv
// Window sequencer for the conv line-buffer datapath: accepts the raster pixel stream,
// drives the line-buffer shift enable and flags complete, stride-aligned windows.
module conv_window_ctrl #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int KERNEL     = 3,
    parameter int STRIDE     = 1,
    localparam int OUT_W = (IMG_WIDTH - KERNEL) / STRIDE + 1,
    localparam int OUT_H = (IMG_HEIGHT - KERNEL) / STRIDE + 1,
    localparam int OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int OR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            shift_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OR_W-1:0] out_row,
    output logic [OC_W-1:0] out_col,
    output logic            busy,
    output logic            frame_done
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0]   COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]   COL_K1    = CW'(KERNEL - 1);
    localparam logic [RW-1:0]   ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0]   ROW_K1    = RW'(KERNEL - 1);
    localparam logic [PW-1:0]   PH_LAST   = PW'(STRIDE - 1);
    localparam logic [OC_W-1:0] OCOL_LAST = OC_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   col_r;
    logic [RW-1:0]   row_r;
    logic [PW-1:0]   cph_r;
    logic [PW-1:0]   rph_r;
    logic [OC_W-1:0] nxt_ocol_r;
    logic [OR_W-1:0] nxt_orow_r;
    logic            out_valid_r;
    logic [OR_W-1:0] out_row_r;
    logic [OC_W-1:0] out_col_r;
    logic            busy_r;
    logic            frame_done_r;

    logic            in_ready_s;
    logic            accept_s;
    logic            win_s;
    logic            last_pix_s;
    logic            start_frame_s;

    assign accept_s      = in_valid && in_ready_s;
    assign win_s         = (row_r >= ROW_K1) && (col_r >= COL_K1) &&
                           (rph_r == {PW{1'b0}}) && (cph_r == {PW{1'b0}});
    assign last_pix_s    = (row_r == ROW_LAST) && (col_r == COL_LAST);
    assign start_frame_s = (state_r == ST_IDLE) && (state_s == ST_RUN);

    // Next-state and handshake decode
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // the frame_done cycle is still the tail of the old frame
                if (start && !frame_done_r) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                in_ready_s = !out_valid_r || out_ready;
                if (accept_s && last_pix_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_r || out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with busy and end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_r == ST_DRAIN) && (state_s == ST_IDLE);
        end
    end

    // Raster position, stride phases and flagged-window coordinates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            cph_r       <= {PW{1'b0}};
            rph_r       <= {PW{1'b0}};
            nxt_ocol_r  <= {OC_W{1'b0}};
            nxt_orow_r  <= {OR_W{1'b0}};
            out_valid_r <= 1'b0;
            out_row_r   <= {OR_W{1'b0}};
            out_col_r   <= {OC_W{1'b0}};
        end else if (start_frame_s) begin
            col_r       <= {CW{1'b0}};
            row_r       <= {RW{1'b0}};
            cph_r       <= {PW{1'b0}};
            rph_r       <= {PW{1'b0}};
            nxt_ocol_r  <= {OC_W{1'b0}};
            nxt_orow_r  <= {OR_W{1'b0}};
            out_valid_r <= 1'b0;
            out_row_r   <= {OR_W{1'b0}};
            out_col_r   <= {OC_W{1'b0}};
        end else if (accept_s) begin
            // phases stay 0 until the position reaches KERNEL-1, then count modulo STRIDE
            if (col_r == COL_LAST) begin
                col_r <= {CW{1'b0}};
                cph_r <= {PW{1'b0}};
                row_r <= row_r + RW'(1);
                if (row_r < ROW_K1) begin
                    rph_r <= {PW{1'b0}};
                end else if (rph_r == PH_LAST) begin
                    rph_r <= {PW{1'b0}};
                end else begin
                    rph_r <= rph_r + PW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
                if (col_r < COL_K1) begin
                    cph_r <= {PW{1'b0}};
                end else if (cph_r == PH_LAST) begin
                    cph_r <= {PW{1'b0}};
                end else begin
                    cph_r <= cph_r + PW'(1);
                end
            end
            out_valid_r <= win_s;
            if (win_s) begin
                out_row_r <= nxt_orow_r;
                out_col_r <= nxt_ocol_r;
                if (nxt_ocol_r == OCOL_LAST) begin
                    nxt_ocol_r <= {OC_W{1'b0}};
                    nxt_orow_r <= nxt_orow_r + OR_W'(1);
                end else begin
                    nxt_ocol_r <= nxt_ocol_r + OC_W'(1);
                end
            end else begin
                out_row_r <= out_row_r;
                out_col_r <= out_col_r;
            end
        end else if (!out_valid_r || out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign shift_en   = accept_s;
    assign out_valid  = out_valid_r;
    assign out_row    = out_row_r;
    assign out_col    = out_col_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: a pixel-index model checks the default-size instance every
// cycle; a 5x5/K3/S2 instance is checked against hand-computed windows.
module tb_conv_window_ctrl;

    localparam int W = 28;
    localparam int H = 28;
    localparam int K = 3;
    localparam int S = 1;
    localparam int OW = (W - K) / S + 1;

    logic       clk;
    logic       reset;
    logic       start, in_valid, out_ready;
    logic       in_ready, shift_en, out_valid, busy, frame_done;
    logic [4:0] out_row, out_col;

    logic       s_start, s_in_valid, s_out_ready;
    logic       s_in_ready, s_shift_en, s_out_valid, s_busy, s_frame_done;
    logic [0:0] s_out_row, s_out_col;

    int n_vec = 0;
    int n_err = 0;

    conv_window_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .shift_en(shift_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .busy(busy), .frame_done(frame_done)
    );

    conv_window_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .KERNEL(3), .STRIDE(2)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .shift_en(s_shift_en), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_row(s_out_row), .out_col(s_out_col),
        .busy(s_busy), .frame_done(s_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model state: 0 idle, 1 run, 2 drain; m_pix = pixels accepted this frame
    int   m_state = 0, m_pix = 0, m_or = 0, m_oc = 0;
    logic m_ov = 1'b0, m_fd = 1'b0, m_busy = 1'b0;

    // observed history
    int         tot_shift = 0, tot_fd = 0;
    logic [9:0] win_q[$];
    int         acc_q[$];
    int         s_tot_shift = 0, s_tot_fd = 0;
    logic [1:0] s_win_q[$];
    int         s_acc_q[$];

    // compare process: model steps on the falling edge with the inputs the DUT sees next
    initial begin
        int   mr, mc, exp_ir;
        logic fd_old, acc;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_state = 0; m_pix = 0; m_or = 0; m_oc = 0;
                m_ov = 1'b0; m_fd = 1'b0; m_busy = 1'b0;
            end
            exp_ir = (m_state == 1 && (!m_ov || out_ready)) ? 1 : 0;
            chk("in_ready", int'(in_ready), exp_ir);
            chk("shift_en", int'(shift_en), (exp_ir == 1 && in_valid) ? 1 : 0);
            chk("out_valid", int'(out_valid), int'(m_ov));
            if (m_ov) begin
                chk("out_row", int'(out_row), m_or);
                chk("out_col", int'(out_col), m_oc);
            end
            chk("busy", int'(busy), int'(m_busy));
            chk("frame_done", int'(frame_done), int'(m_fd));

            if (out_valid && out_ready) begin
                win_q.push_back({out_row, out_col});
                acc_q.push_back(tot_shift);
            end
            if (shift_en) tot_shift++;
            if (frame_done) tot_fd++;
            if (s_out_valid && s_out_ready) begin
                s_win_q.push_back({s_out_row, s_out_col});
                s_acc_q.push_back(s_tot_shift);
            end
            if (s_shift_en) s_tot_shift++;
            if (s_frame_done) s_tot_fd++;

            if (!reset) begin
                fd_old = m_fd;
                m_fd   = 1'b0;
                acc    = in_valid && exp_ir == 1;
                if (m_state == 0) begin
                    if (start && !fd_old) begin
                        m_state = 1; m_pix = 0; m_ov = 1'b0; m_or = 0; m_oc = 0;
                    end
                end else if (m_state == 1) begin
                    if (acc) begin
                        mr = m_pix / W;
                        mc = m_pix % W;
                        if (mr >= K - 1 && mc >= K - 1 && (mr - K + 1) % S == 0 && (mc - K + 1) % S == 0) begin
                            m_ov = 1'b1;
                            m_or = (mr - K + 1) / S;
                            m_oc = (mc - K + 1) / S;
                        end else begin
                            m_ov = 1'b0;
                        end
                        m_pix++;
                        if (m_pix == W * H) m_state = 2;
                    end else if (!m_ov || out_ready) begin
                        m_ov = 1'b0;
                    end
                end else begin
                    if (!m_ov || out_ready) begin
                        m_ov = 1'b0; m_fd = 1'b1; m_state = 0;
                    end
                end
                m_busy = (m_state != 0);
            end
        end
    end

    int sb, wb, fb;

    task automatic run_frame(input bit iv_rand, input bit stall, input bit hold_start, input int stop_at);
        int cyc, stall_cnt;
        sb = tot_shift; wb = win_q.size(); fb = tot_fd;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        cyc = 0; stall_cnt = 0;
        while (tot_fd == fb && cyc < 4000 && !(stop_at > 0 && tot_shift - sb >= stop_at)) begin
            in_valid = iv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && out_valid && (win_q.size() - wb) == 9 && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
                #1;
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_shift_en", int'(shift_en), 0);
                chk("stall_out_row", int'(out_row), 0);
                chk("stall_out_col", int'(out_col), 9);
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (stop_at == 0) chk("frame_timeout", (cyc < 4000) ? 1 : 0, 1);
    endtask

    task automatic frame_checks();
        int hs, bad;
        hs = win_q.size() - wb;
        chk("frame_shifts", tot_shift - sb, 784);
        chk("frame_windows", hs, 676);
        chk("frame_done_pulses", tot_fd - fb, 1);
        if (hs == 676) begin
            chk("first_win_accepts", acc_q[wb] - sb, 59);
            chk("first_win_coord", int'(win_q[wb]), 0);
            chk("last_win_coord", int'(win_q[wb + 675]), 25 * 32 + 25);
            bad = 0;
            for (int i = 0; i < 676; i++) begin
                if (win_q[wb + i] !== {5'(i / OW), 5'(i % OW)}) bad++;
            end
            chk("window_sequence_errors", bad, 0);
        end
    endtask

    initial begin
        int exp_acc[4];
        int swb, ssb, sfb, cyc;
        exp_acc = '{13, 15, 23, 25};
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_coords", int'({out_row, out_col}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        // full throughput
        run_frame(1'b0, 1'b0, 1'b0, 0);
        frame_checks();
        // 3-cycle backpressure on the 10th window
        run_frame(1'b0, 1'b1, 1'b0, 0);
        frame_checks();
        // ~50% input gaps
        run_frame(1'b1, 1'b0, 1'b0, 0);
        frame_checks();

        // asynchronous reset mid-row after 300 pixels
        run_frame(1'b0, 1'b0, 1'b0, 300);
        #1 reset = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_shift_en", int'(shift_en), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_coords", int'({out_row, out_col}), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        @(posedge clk); #1 reset = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, 0);
        frame_checks();

        // start held high through the frame and its frame_done cycle
        run_frame(1'b0, 1'b0, 1'b1, 0);
        frame_checks();
        chk("held_start_busy_after_done", int'(busy), 0);
        @(posedge clk); #1;
        chk("held_start_busy_restart", int'(busy), 1);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;

        // 5x5, kernel 3, stride 2
        swb = s_win_q.size(); ssb = s_tot_shift; sfb = s_tot_fd;
        @(posedge clk); #1;
        s_start = 1'b1; s_in_valid = 1'b1; s_out_ready = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        cyc = 0;
        while (s_tot_fd == sfb && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("s_timeout", (cyc < 200) ? 1 : 0, 1);
        chk("s_shifts", s_tot_shift - ssb, 25);
        chk("s_windows", s_win_q.size() - swb, 4);
        chk("s_frame_done_pulses", s_tot_fd - sfb, 1);
        if (s_win_q.size() - swb == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("s_win_coord", int'(s_win_q[swb + i]), i);
                chk("s_win_accepts", s_acc_q[swb + i] - ssb, exp_acc[i]);
            end
        end
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
